// File: rtl/qed_dup_scheduler.sv
// qed_dup_scheduler: alternates ORIG/DUP phases for QED instruction duplication and pulses qed_check after each drain.
module qed_dup_scheduler #(
  parameter int MAX_ORIG = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             stall_IF,
  input  logic             ifu_vld,
  input  logic             vld_out,
  input  logic             orig_done,
  output logic             exec_dup,
  output logic             qed_check,
  output logic [CNT_W-1:0] pending,
  output logic [1:0]       sched_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ORIG = 2'd1, DUP = 2'd2, CHECK = 2'd3} state_t;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ORIG);
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_pending, w_pending_nxt, w_sum, w_dif;
  logic             w_issue_o, w_issue_d;
  assign w_issue_o = (r_state == ORIG) & ifu_vld & ~stall_IF;
  assign w_issue_d = (r_state == DUP) & vld_out & ~stall_IF & (r_pending != '0);
  assign w_sum     = r_pending + CNT_W'(w_issue_o);
  assign w_dif     = r_pending - CNT_W'(w_issue_d);
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = '0;
    case (r_state)
      IDLE:  w_state_nxt = ena ? ORIG : IDLE;
      ORIG: begin
        w_pending_nxt = w_sum;
        w_state_nxt   = (w_sum == MAX_CNT || (w_sum != '0 && (orig_done || !ena))) ? DUP :
                        !ena ? IDLE : ORIG;
      end
      DUP: begin
        w_pending_nxt = w_dif;
        w_state_nxt   = (w_dif == '0) ? CHECK : DUP;
      end
      default: w_state_nxt = ena ? ORIG : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end
  assign exec_dup    = (r_state == DUP);
  assign qed_check   = (r_state == CHECK);
  assign pending     = r_pending;
  assign sched_state = r_state;
endmodule

// File: doc/qed_dup_scheduler.md
Name: qed_dup_scheduler

Overview:
- Sequencing controller for the QED instruction-duplication datapath.
- Drives exec_dup for the QED module. Alternates between an ORIG phase, in which original instructions pass through and are counted, and a DUP phase, in which the same number of duplicate instructions is issued from the QED i-cache.
- After every DUP phase it emits a one-cycle qed_check pulse marking a consistent point for the original/duplicate register-state comparison.

Parameters:
- MAX_ORIG, 16: maximum original instructions issued before a forced switch to DUP; range 1..(2^CNT_W - 1).
- CNT_W, 5: width of the pending counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- ena  input  1  QED mode enable. Same signal as the QED module ena.
- stall_IF  input  1  fetch stall. No issue is counted in a stalled cycle.
- ifu_vld  input  1  a valid original instruction is fetched this cycle.
- vld_out  input  1  the QED i-cache presents a valid duplicate this cycle.
- orig_done  input  1  request for an early switch to DUP, e.g. at a sequence boundary.
- exec_dup  output  1  1 = the QED mux selects the duplicate instruction.
- qed_check  output  1  single-cycle pulse; the states are now comparable.
- pending  output  CNT_W  originals issued but not yet duplicated.
- sched_state  output  2  FSM state: IDLE=0, ORIG=1, DUP=2, CHECK=3.

Behaviour:

Clock and reset:
- One clock.
- Reset is asynchronous and active-high on rst. All state flops clear immediately on rst=1, regardless of clk.
- Reset values: state=IDLE, pending=0, exec_dup=0, qed_check=0, sched_state=0.
- Reset mid-operation abandons any in-flight ORIG or DUP phase; no qed_check is emitted.

Event definitions:
- issue_o = (state==ORIG) & ifu_vld & ~stall_IF
- issue_d = (state==DUP) & vld_out & ~stall_IF & (pending!=0)

State transitions (all registered, effective next cycle):
- IDLE:
  - ena=1 -> ORIG.
  - pending stays 0.
- ORIG:
  - pending increments on issue_o.
  - -> DUP when (pending+issue_o)==MAX_ORIG.
  - -> DUP when orig_done=1 and (pending+issue_o)>0.
  - -> DUP when ena=0 and (pending+issue_o)>0. ena deassert forces a drain.
  - -> IDLE when ena=0 and (pending+issue_o)==0.
  - orig_done with zero pending is ignored; state stays ORIG.
- DUP:
  - pending decrements on issue_d.
  - -> CHECK when (pending-issue_d)==0.
  - ena and orig_done are ignored; the drain always completes.
  - vld_out while stall_IF=1 is not counted.
- CHECK:
  - Lasts exactly one cycle, with qed_check=1.
  - -> ORIG if ena=1, else -> IDLE.

Output rules:
- exec_dup is a registered decode: 1 exactly while state==DUP.
- qed_check is a registered decode: 1 exactly while state==CHECK.
- sched_state is the raw state register.
- Latency: the first cycle of exec_dup=1 is the cycle after the issue or request that triggered the switch. The qed_check cycle immediately follows the final counted duplicate.

Arithmetic and range:
- pending never exceeds MAX_ORIG and never underflows.
- ifu_vld outside ORIG and vld_out outside DUP are ignored.
- Simultaneous orig_done and the MAX_ORIG hit produce a single switch to DUP.

Test Plan:
1. Reset check: rst pulsed with clk stopped -> all outputs 0 immediately. ena=1 then gives sched_state=1 on the next edge.
2. Forced switch at the limit: MAX_ORIG=4, four unstalled ifu_vld pulses -> pending 1,2,3,4; exec_dup=1 the next cycle.
   - Then four vld_out pulses -> pending 3,2,1,0.
   - Then one qed_check cycle, then sched_state=1 with exec_dup=0.
3. Stall masking: three originals with stall_IF=1 on the 2nd -> pending=2.
   - Then orig_done -> DUP.
   - vld_out with stall_IF=1 leaves pending at 2; two unstalled vld_out pulses -> CHECK.
4. Early request with nothing pending: orig_done with pending=0 -> state stays ORIG and exec_dup=0. ena=0 with pending=0 -> IDLE.
5. ena drop mid-phase:
   - ena=0 in ORIG with pending=3 -> DUP.
   - Drain of 3 -> CHECK pulse -> IDLE.
   - ena toggles during DUP -> no effect on the drain.
6. Reset mid-DUP: pending=5, rst asserted -> immediate IDLE with pending=0; no qed_check pulse.
